// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider state encoding, iteration count and the
// ALUControl codes that the EX decode turns into start/signed_div.
package cpu_defs;

    localparam int DIV_ITER = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;

    localparam logic [3:0] ALU_DIV  = 4'd12;
    localparam logic [3:0] ALU_DIVU = 4'd13;

    function automatic logic isDivOp(input logic [3:0] aluControl);
        return (aluControl == ALU_DIV) || (aluControl == ALU_DIVU);
    endfunction

    function automatic logic isSignedDiv(input logic [3:0] aluControl);
        return aluControl == ALU_DIV;
    endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// EX-stage divider interface: request/operands from the pipeline, stall and
// results back to it.
interface ex_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic             signed_div;
    logic             advance;
    logic             annul;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_div, advance, annul, opa, opb,
        input  stall_req, done, quotient, remainder
    );

    modport slave (
        input  start, signed_div, advance, annul, opa, opb,
        output stall_req, done, quotient, remainder
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,dividend} left, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] nextRem,
    output logic [WIDTH-1:0] nextDividend,
    output logic             qBit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // trial subtraction on a WIDTH+1 bit window so the borrow is visible
    always_comb begin
        shifted      = {rem, dividend[WIDTH-1]};
        diff         = shifted - {1'b0, divisor};
        qBit         = ~diff[WIDTH];
        nextDividend = {dividend[WIDTH-2:0], 1'b0};
        if (qBit) begin
            nextRem = diff[WIDTH-1:0];
        end else begin
            nextRem = shifted[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage; quotient goes to LO,
// remainder to HI, and the pipeline is held via stall_req while it runs.
module ex_div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_ITER,
    parameter int CNT_W = 5
) (
    input logic         clk,
    input logic         reset,
    ex_div_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       stateR;
    logic [CNT_W-1:0] cntR;
    logic [WIDTH-1:0] remR, dvdR, dvsR, opaR, quotR, remOutR;
    logic             negQR, negRR, zeroR, doneR;

    logic [WIDTH-1:0] stepRem, stepDvd, absA, absB, fixQ, fixR;
    logic             stepQ;

    div_step #(.WIDTH(WIDTH)) uStep (
        .rem          (remR),
        .dividend     (dvdR),
        .divisor      (dvsR),
        .nextRem      (stepRem),
        .nextDividend (stepDvd),
        .qBit         (stepQ)
    );

    // operand magnitudes and the sign/zero fixup applied in FIX
    always_comb begin
        absA = (bus.signed_div && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
        absB = (bus.signed_div && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
        if (zeroR) begin
            fixQ = '1;
            fixR = opaR;
        end else begin
            fixQ = negQR ? -dvdR : dvdR;
            fixR = negRR ? -remR : remR;
        end
    end

    assign bus.stall_req = ~bus.annul &
                           (((stateR == DIV_IDLE) & bus.start) |
                            (stateR == DIV_RUN) | (stateR == DIV_FIX));
    assign bus.done      = doneR;
    assign bus.quotient  = quotR;
    assign bus.remainder = remOutR;

    // divider FSM, iteration datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR  <= DIV_IDLE;
            cntR    <= '0;
            remR    <= '0;
            dvdR    <= '0;
            dvsR    <= '0;
            opaR    <= '0;
            quotR   <= '0;
            remOutR <= '0;
            negQR   <= 1'b0;
            negRR   <= 1'b0;
            zeroR   <= 1'b0;
            doneR   <= 1'b0;
        end else if (bus.annul) begin
            // results stay as they were; the cancelled op never signals done
            stateR <= DIV_IDLE;
            cntR   <= '0;
            doneR  <= 1'b0;
        end else begin
            case (stateR)
                DIV_IDLE: begin
                    if (bus.start) begin
                        dvdR   <= absA;
                        dvsR   <= absB;
                        opaR   <= bus.opa;
                        remR   <= '0;
                        negQR  <= bus.signed_div & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                        negRR  <= bus.signed_div & bus.opa[WIDTH-1];
                        zeroR  <= (bus.opb == '0);
                        cntR   <= '0;
                        stateR <= DIV_RUN;
                    end else begin
                        stateR <= DIV_IDLE;
                    end
                end
                DIV_RUN: begin
                    remR <= stepRem;
                    dvdR <= stepDvd | WIDTH'(stepQ);
                    if (cntR == CNT_LAST) begin
                        stateR <= DIV_FIX;
                    end else begin
                        cntR <= cntR + CNT_ONE;
                    end
                end
                DIV_FIX: begin
                    quotR   <= fixQ;
                    remOutR <= fixR;
                    doneR   <= 1'b1;
                    stateR  <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (bus.advance) begin
                        stateR <= DIV_IDLE;
                        doneR  <= 1'b0;
                    end else begin
                        stateR <= DIV_DONE;
                    end
                end
                default: begin
                    stateR <= DIV_IDLE;
                    doneR  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed vector table, random operands
// against an arithmetic reference, and annul/hold/reset sequences.
module tb_ex_div_unit;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] lastQ = 32'd0;
    logic [31:0] lastR = 32'd0;

    ex_div_unit_if #(.WIDTH(32)) bus ();

    ex_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // reference: plain integer arithmetic with the divide-by-zero and overflow rules
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // issue one divide and leave the DUT in DONE with start still high
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [31:0] expQ, input logic [31:0] expR);
        int   k;
        logic stallBad;
        bus.opa        = a;
        bus.opb        = b;
        bus.signed_div = sgn;
        bus.start      = 1'b1;
        bus.advance    = 1'b0;
        #1;
        chk("stallIdleStart", 32'(bus.stall_req), 32'd1);
        @(posedge clk); #1;
        bus.opa = $urandom;
        bus.opb = $urandom;
        k = 0;
        stallBad = 1'b0;
        while (!bus.done && k < 100) begin
            if (!bus.stall_req) stallBad = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 32'(k), 32'd33);
        chk("stallDuringOp", 32'(stallBad), 32'd0);
        chk("quotient", bus.quotient, expQ);
        chk("remainder", bus.remainder, expR);
        chk("stallInDone", 32'(bus.stall_req), 32'd0);
        lastQ = expQ;
        lastR = expR;
    endtask

    task automatic leaveDone();
        bus.start   = 1'b0;
        bus.advance = 1'b1;
        @(posedge clk); #1;
        bus.advance = 1'b0;
        chk("doneClearedAfterAdvance", 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, q, r;
        logic        s, seen;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234};
        vecs[4] = '{32'hFFFF_FF00,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FF00};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[6] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
        vecs[7] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5};
        vecs[8] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};

        reset = 1'b1;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.advance = 1'b0; bus.annul = 1'b0;
        bus.opa = 32'd0; bus.opb = 32'd0;
        #12;
        chk("rstDone", 32'(bus.done), 32'd0);
        chk("rstQuot", bus.quotient, 32'd0);
        chk("rstRem", bus.remainder, 32'd0);
        chk("rstStall", 32'(bus.stall_req), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            runDiv(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r);
            leaveDone();
        end

        // annul mid-divide: back to IDLE, results untouched, no done
        bus.opa = 32'd1000; bus.opb = 32'd3; bus.signed_div = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        bus.annul = 1'b1;
        #1;
        chk("annulStallLow", 32'(bus.stall_req), 32'd0);
        @(posedge clk); #1;
        bus.annul = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("annulIdle", 32'(bus.stall_req), 32'd0);
        chk("annulQuotKept", bus.quotient, lastQ);
        chk("annulRemKept", bus.remainder, lastR);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
        chk("annulNoDone", 32'(seen), 32'd0);
        runDiv(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);
        leaveDone();

        // annul together with start in IDLE: nothing starts
        bus.opa = 32'd50; bus.opb = 32'd5; bus.start = 1'b1; bus.annul = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.annul = 1'b0;
        #1;
        chk("annulStartIgnored", 32'(bus.stall_req), 32'd0);
        @(posedge clk); #1;
        chk("annulStartNoDone", 32'(bus.done), 32'd0);

        // advance withheld in DONE, then back-to-back with start held high
        runDiv(32'd12345, 32'd100, 1'b0, 32'd123, 32'd45);
        bus.opa = 32'hFFFF_FF9C; bus.opb = 32'd9; bus.signed_div = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("holdDone", 32'(bus.done), 32'd1);
            chk("holdQuot", bus.quotient, 32'd123);
            chk("holdRem", bus.remainder, 32'd45);
            chk("holdStall", 32'(bus.stall_req), 32'd0);
        end
        bus.advance = 1'b1;
        @(posedge clk); #1;
        bus.advance = 1'b0;
        #1;
        chk("b2bDoneLow", 32'(bus.done), 32'd0);
        chk("b2bIdleStall", 32'(bus.stall_req), 32'd1);
        runDiv(32'hFFFF_FF9C, 32'd9, 1'b1, 32'hFFFF_FFF5, 32'hFFFF_FFFF);
        leaveDone();

        // asynchronous reset pulse mid-divide
        bus.opa = 32'd77; bus.opb = 32'd4; bus.signed_div = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        repeat (19) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("asyncRstQuot", bus.quotient, 32'd0);
        chk("asyncRstRem", bus.remainder, 32'd0);
        chk("asyncRstDone", 32'(bus.done), 32'd0);
        chk("asyncRstStall", 32'(bus.stall_req), 32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("postRstIdle", 32'(bus.stall_req), 32'd0);
        runDiv(32'd77, 32'd4, 1'b0, 32'd19, 32'd1);
        leaveDone();

        // random operands against the reference model
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            s = 1'($urandom_range(0, 1));
            model(a, b, s, q, r);
            runDiv(a, b, s, q, r);
            leaveDone();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
